// File: rtl/reg_bank_mux.sv
// Register bank with one synchronous write port and two independent registered read ports.
// Same-cycle write-to-read bypass, optional hard-wired zero register, out-of-range reads return 0.
module reg_bank_mux #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter bit R0_ZERO = 1'b0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Non-power-of-two depths leave part of the address space unbacked.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  assign wr_ok = wr_en && addr_ok(wr_addr) && !(R0_ZERO && (wr_addr == '0));

  // Bypass only from a write that will actually land, so a dropped write never leaks through.
  always_comb begin
    sel_a = '0;
    if (!addr_ok(rd_addr_a) || (R0_ZERO && (rd_addr_a == '0))) begin
      sel_a = '0;
    end else if (wr_ok && (wr_addr == rd_addr_a)) begin
      sel_a = wr_data;
    end else begin
      sel_a = regs[rd_addr_a];
    end
  end

  always_comb begin
    sel_b = '0;
    if (!addr_ok(rd_addr_b) || (R0_ZERO && (rd_addr_b == '0))) begin
      sel_b = '0;
    end else if (wr_ok && (wr_addr == rd_addr_b)) begin
      sel_b = wr_data;
    end else begin
      sel_b = regs[rd_addr_b];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read data holds its last value while a port is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
      rd_data_b  <= '0;
      rd_valid_b <= 1'b0;
    end else begin
      rd_valid_a <= rd_en_a;
      rd_valid_b <= rd_en_b;
      if (rd_en_a) begin
        rd_data_a <= sel_a;
      end
      if (rd_en_b) begin
        rd_data_b <= sel_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_mux.sv
// Scoreboard bench for reg_bank_mux: three variants (plain, R0_ZERO, DEPTH=12) share one stimulus.
// Expected read results are queued at issue time and popped by a negedge monitor on each valid.
module tb_reg_bank_mux;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en_a, rd_en_b;
  logic [3:0]  rd_addr_a, rd_addr_b;

  // port index p: instance p/2, port A when p is even
  logic [15:0] rdd [6];
  logic        rdv [6];

  logic [15:0] exp_q [6][$];
  logic [15:0] last [6];
  logic [15:0] mdl [3][16];

  int n_cmp;
  int n_fail;

  reg_bank_mux #(.WIDTH(16), .DEPTH(16), .R0_ZERO(1'b0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rdd[0]), .rd_valid_a(rdv[0]),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rdd[1]), .rd_valid_b(rdv[1]));

  reg_bank_mux #(.WIDTH(16), .DEPTH(16), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rdd[2]), .rd_valid_a(rdv[2]),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rdd[3]), .rd_valid_b(rdv[3]));

  reg_bank_mux #(.WIDTH(16), .DEPTH(12), .R0_ZERO(1'b0)) dut_12 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rdd[4]), .rd_valid_a(rdv[4]),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rdd[5]), .rd_valid_b(rdv[5]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 2) ? 12 : 16;
  endfunction

  function automatic bit r0z_of(input int k);
    return k == 1;
  endfunction

  function automatic bit w_legal(input int k, input bit we, input logic [3:0] wa);
    return we && (int'(wa) < depth_of(k)) && !(r0z_of(k) && wa == 4'd0);
  endfunction

  function automatic logic [15:0] model_sel(input int k, input bit we, input logic [3:0] wa,
                                            input logic [15:0] wd, input logic [3:0] a);
    if (int'(a) >= depth_of(k)) return 16'h0;
    if (r0z_of(k) && a == 4'd0) return 16'h0;
    if (w_legal(k, we, wa) && wa == a) return wd;
    return mdl[k][a];
  endfunction

  // One cycle of stimulus; useh replaces the plain instance's expectation with a hand value.
  task automatic step(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                      input bit ea, input logic [3:0] aa, input bit eb, input logic [3:0] ab,
                      input bit useh = 1'b0, input logic [15:0] ha = 16'h0,
                      input logic [15:0] hb = 16'h0);
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    for (int k = 0; k < 3; k++) begin
      if (ea) exp_q[2*k].push_back((useh && k == 0) ? ha : model_sel(k, we, wa, wd, aa));
      if (eb) exp_q[2*k+1].push_back((useh && k == 0) ? hb : model_sel(k, we, wa, wd, ab));
    end
    for (int k = 0; k < 3; k++) begin
      if (w_legal(k, we, wa)) mdl[k][wa] = wd;
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0;
    rd_en_a = 1'b0; rd_addr_a = 4'd0; rd_en_b = 1'b0; rd_addr_b = 4'd0;
  endtask

  task automatic clear_model();
    for (int p = 0; p < 6; p++) begin
      exp_q[p].delete();
      last[p] = 16'h0;
    end
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 16; a++) mdl[k][a] = 16'h0;
  endtask

  // Reset lands mid-cycle, after whatever the previous step issued has been captured.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int p = 0; p < 6; p++) begin
      chk($sformatf("rst_data[%0d]", p), rdd[p], 16'h0);
      chk($sformatf("rst_valid[%0d]", p), {15'h0, rdv[p]}, 16'h0);
    end
    idle_inputs();
    clear_model();
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int p = 0; p < 6; p++) begin
        if (rdv[p]) begin
          if (exp_q[p].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid[%0d]: got valid with data %h, want no valid", p, rdd[p]);
          end else begin
            last[p] = exp_q[p].pop_front();
            chk($sformatf("rd_data[%0d]", p), rdd[p], last[p]);
          end
        end else begin
          chk($sformatf("hold[%0d]", p), rdd[p], last[p]);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    idle_inputs();
    clear_model();
    reset = 1'b1;
    #1;
    for (int p = 0; p < 6; p++) begin
      chk($sformatf("init_data[%0d]", p), rdd[p], 16'h0);
      chk($sformatf("init_valid[%0d]", p), {15'h0, rdv[p]}, 16'h0);
    end
    #11;
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      step(1'b1, 4'(i), 16'hA000 + 16'(i), 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++)
      step(1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 1'b1, 4'(15 - i), 1'b1,
           16'hA000 + 16'(i), 16'hA000 + 16'(15 - i));
    // port A idles two cycles: valid drops, data must hold A00F
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 16'h0, 16'hA003);
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1, 4'd4, 1'b1, 16'h0, 16'hA004);

    step(1'b1, 4'd5, 16'h1111, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b1, 4'd5, 16'h2222, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 16'h2222, 16'h2222);
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 16'h2222, 16'h2222);

    // address 0 write+read: bypass on the plain bank, zero on the R0_ZERO bank
    step(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 16'hFFFF, 16'hFFFF);
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 16'hFFFF, 16'hFFFF);

    // address 13 is out of range only for the 12-deep bank
    step(1'b1, 4'd13, 16'hBEEF, 1'b1, 4'd13, 1'b1, 4'd13, 1'b1, 16'hBEEF, 16'hBEEF);
    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 1'b1, 4'd13, 1'b1, 16'hA001, 16'hBEEF);

    step(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b0, 4'd0);
    pulse_reset();
    for (int i = 0; i < 16; i++)
      step(1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 1'b1, 4'(15 - i), 1'b1, 16'h0, 16'h0);

    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        step(1'($urandom), 4'($urandom), 16'($urandom),
             1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
      end
    end

    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    for (int p = 0; p < 6; p++)
      chk($sformatf("drain[%0d]", p), 16'(exp_q[p].size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
